// File: rtl/mfp_ahb_lite_apb_bridge_pkg.sv
// mfp_ahb_lite_apb_bridge_pkg: shared AHB-Lite codes and bridge state type
//   HTRANS_*  : AHB transfer type codes
//   HSIZE_*   : AHB transfer size codes (1, 2, 4 bytes)
//   state_t   : bridge FSM states
package mfp_ahb_lite_apb_bridge_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_1       = 3'd0;
    localparam logic [2:0] HSIZE_2       = 3'd1;
    localparam logic [2:0] HSIZE_4       = 3'd2;
    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;
    function automatic logic [2:0] pprot_map(input logic [3:0] hprot);
        return {~hprot[0], 1'b0, hprot[1]};
    endfunction
endpackage

// File: rtl/mfp_ahb_lite_apb_strobe.sv
// mfp_ahb_lite_apb_strobe: combinational APB byte-strobe generator
//   i_hsize  : AHB size code
//   i_addr   : HADDR[1:0]
//   i_endian : 0 little, 1 big (mirrors byte lanes)
//   i_hwrite : strobes are zero for reads
//   o_pstrb  : APB byte strobes
module mfp_ahb_lite_apb_strobe
    import mfp_ahb_lite_apb_bridge_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addr,
    input  logic       i_endian,
    input  logic       i_hwrite,
    output logic [3:0] o_pstrb
);
    logic [3:0] w_le;
    always_comb begin
        w_le = i_hsize == HSIZE_1 ? 4'b0001 << i_addr :
               i_hsize == HSIZE_2 ? (i_addr[1] ? 4'b1100 : 4'b0011) :
               i_hsize == HSIZE_4 ? 4'b1111 : 4'b0000;
        o_pstrb = ~i_hwrite ? 4'b0000 : i_endian ? {w_le[0], w_le[1], w_le[2], w_le[3]} : w_le;
    end
endmodule

// File: rtl/mfp_ahb_lite_apb_bridge.sv
// mfp_ahb_lite_apb_bridge: AHB-Lite slave converting each transfer into one APB4 transfer
//   i_hclk, i_hreset        : clock, synchronous active-high reset
//   i_h*                    : AHB-Lite slave inputs (hburst/hmastlock ignored)
//   o_hrdata/o_hready/o_hresp : AHB-Lite slave response
//   i_si_endian             : byte-lane order for strobes
//   o_p*                    : APB4 master outputs
//   i_prdata/i_pready/i_pslverr : APB4 slave response
module mfp_ahb_lite_apb_bridge
    import mfp_ahb_lite_apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
)
(
    input  logic                  i_hclk,
    input  logic                  i_hreset,
    input  logic [31:0]           i_haddr,
    input  logic [2:0]            i_hburst,
    input  logic                  i_hmastlock,
    input  logic [3:0]            i_hprot,
    input  logic                  i_hsel,
    input  logic [2:0]            i_hsize,
    input  logic [1:0]            i_htrans,
    input  logic [31:0]           i_hwdata,
    input  logic                  i_hwrite,
    output logic [31:0]           o_hrdata,
    output logic                  o_hready,
    output logic                  o_hresp,
    input  logic                  i_si_endian,
    output logic [ADDR_WIDTH-1:0] o_paddr,
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [31:0]           o_pwdata,
    output logic [3:0]            o_pstrb,
    output logic [2:0]            o_pprot,
    input  logic [31:0]           i_prdata,
    input  logic                  i_pready,
    input  logic                  i_pslverr
);
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [3:0]            r_pstrb;
    logic [2:0]            r_pprot;
    logic [31:0]           r_pwdata;
    logic [CW-1:0]         r_cnt;
    logic [3:0]            w_pstrb;
    logic                  w_accept;
    logic                  w_timeout;
    logic                  w_unused;

    assign w_unused = ^{i_haddr[31:ADDR_WIDTH], i_hburst, i_hmastlock, i_hprot[3:2], i_htrans[0]};

    mfp_ahb_lite_apb_strobe u_strobe (
        .i_hsize  (i_hsize),
        .i_addr   (i_haddr[1:0]),
        .i_endian (i_si_endian),
        .i_hwrite (i_hwrite),
        .o_pstrb  (w_pstrb)
    );

    // Timeout fires on the last permitted ACCESS cycle, which then carries the
    // first (HREADY=0) half of the ERROR response.
    always_comb begin
        w_next    = r_state;
        o_hready  = 1'b1;
        o_hresp   = 1'b0;
        o_psel    = 1'b0;
        o_penable = 1'b0;
        w_timeout = (TIMEOUT != 0) && !i_pready && (r_cnt == CNT_LAST);
        case (r_state)
            ST_IDLE: w_next = ST_IDLE;
            ST_SETUP: begin
                o_psel   = 1'b1;
                o_hready = 1'b0;
                w_next   = ST_ACCESS;
            end
            ST_ACCESS: begin
                o_psel    = 1'b1;
                o_penable = 1'b1;
                o_hready  = i_pready & ~i_pslverr;
                o_hresp   = (i_pready & i_pslverr) | w_timeout;
                w_next    = i_pready ? (i_pslverr ? ST_ERR2 : ST_IDLE) : (w_timeout ? ST_ERR2 : ST_ACCESS);
            end
            ST_ERR1: begin
                o_hready = 1'b0;
                o_hresp  = 1'b1;
                w_next   = ST_ERR2;
            end
            ST_ERR2: begin
                o_hresp = 1'b1;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // HREADY is only high in states whose natural successor is IDLE, so a new
        // address phase can simply override the next state (back-to-back).
        w_accept = i_hsel & i_htrans[1] & o_hready;
        if (w_accept) w_next = (i_hsize > HSIZE_4) ? ST_ERR1 : ST_SETUP;
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state  <= ST_IDLE;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
            r_pwdata <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_paddr  <= i_haddr[ADDR_WIDTH-1:0];
                r_pwrite <= i_hwrite;
                r_pstrb  <= w_pstrb;
                r_pprot  <= pprot_map(i_hprot);
            end
            if (r_state == ST_SETUP) r_pwdata <= i_hwdata;
            r_cnt <= (r_state == ST_SETUP) ? '0 :
                     (r_state == ST_ACCESS && !i_pready && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
        end
    end

    assign o_hrdata = i_prdata;
    assign o_paddr  = r_paddr;
    assign o_pwrite = r_pwrite;
    assign o_pstrb  = r_pstrb;
    assign o_pprot  = r_pprot;
    // HWDATA is only valid in the data phase, so SETUP forwards it directly.
    assign o_pwdata = (r_state == ST_SETUP) ? i_hwdata : r_pwdata;
endmodule

// File: tb/tb_mfp_ahb_lite_apb_bridge.sv
// tb_mfp_ahb_lite_apb_bridge: self-checking bench for the AHB-Lite to APB bridge
module tb_mfp_ahb_lite_apb_bridge;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] haddr = '0;
    logic [2:0]  hburst = 3'd1;
    logic        hmastlock = 1'b0;
    logic [3:0]  hprot = '0;
    logic        hsel = 1'b0;
    logic [2:0]  hsize = '0;
    logic [1:0]  htrans = '0;
    logic [31:0] hwdata = '0;
    logic        hwrite = 1'b0;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        endian = 1'b0;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    mfp_ahb_lite_apb_bridge #(.ADDR_WIDTH(16), .TIMEOUT(TO)) dut (
        .i_hclk(clk), .i_hreset(rst), .i_haddr(haddr), .i_hburst(hburst), .i_hmastlock(hmastlock),
        .i_hprot(hprot), .i_hsel(hsel), .i_hsize(hsize), .i_htrans(htrans), .i_hwdata(hwdata),
        .i_hwrite(hwrite), .o_hrdata(hrdata), .o_hready(hready), .o_hresp(hresp),
        .i_si_endian(endian), .o_paddr(paddr), .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite),
        .o_pwdata(pwdata), .o_pstrb(pstrb), .o_pprot(pprot), .i_prdata(prdata), .i_pready(pready),
        .i_pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic        endian;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        slverr;
        logic [3:0]  e_strb;
        int          e_low;
        logic        e_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: strobes from the set of byte lanes touched, response and stall
    // length from the transfer outcome (ok / slave error / timeout / bad size).
    function automatic vec_t model(input vec_t v);
        logic [3:0] s;
        int n, base, lane;
        s = '0;
        if (v.wr && v.size <= 2) begin
            n    = 1 << v.size;
            base = (v.size == 2) ? 0 : (v.size == 1) ? int'(v.addr[1]) * 2 : int'(v.addr[1:0]);
            for (int k = 0; k < n; k++) begin
                lane = base + k;
                if (v.endian) lane = 3 - lane;
                s[lane] = 1'b1;
            end
        end
        v.e_strb = s;
        v.e_err  = (v.size > 2) || (v.waits >= TO) || v.slverr;
        v.e_low  = (v.size > 2) ? 1 : (v.waits >= TO) ? 1 + TO : 1 + v.waits + int'(v.slverr);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int low, acc, setup;
        logic done, last_resp, psel_seen, fin_resp, cap_wr;
        logic [31:0] rd, cap_wdata;
        logic [15:0] cap_addr;
        logic [3:0] cap_strb;
        logic [2:0] cap_prot;
        haddr = v.addr; hwrite = v.wr; hsize = v.size; hprot = v.prot; endian = v.endian;
        hsel = 1'b1; htrans = 2'b10; hwdata = '0;
        #1 chk({tag, " accept_rdy"}, 32'(hready), 32'd1);
        @(posedge clk); #1;
        htrans = 2'b00; hsel = 1'b0; hwdata = v.wdata;
        low = 0; acc = 0; setup = 0; done = 0; last_resp = 0; psel_seen = 0; fin_resp = 0; rd = '0;
        cap_wr = 0; cap_wdata = '0; cap_addr = '0; cap_strb = '0; cap_prot = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (psel && penable) begin
                pready = (acc >= v.waits); pslverr = pready & v.slverr; prdata = v.rdata;
            end else begin
                pready = 1'b0; pslverr = 1'b0;
            end
            #1;
            if (psel) begin
                psel_seen = 1'b1;
                if (!penable) setup++;
                else begin
                    if (acc == 0) begin
                        cap_addr = paddr; cap_wr = pwrite; cap_strb = pstrb; cap_prot = pprot; cap_wdata = pwdata;
                    end
                    acc++;
                end
            end
            if (hready) begin
                done = 1'b1; fin_resp = hresp; rd = hrdata;
            end else begin
                low++; last_resp = hresp;
            end
        end
        chk({tag, " complete"}, 32'(done), 32'd1);
        if (!done) begin
            rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        end
        chk({tag, " hready_low_cycles"}, 32'(low), 32'(v.e_low));
        chk({tag, " final_hresp"}, 32'(fin_resp), 32'(v.e_err));
        chk({tag, " first_err_cycle_hresp"}, 32'(last_resp), 32'(v.e_err));
        chk({tag, " psel_seen"}, 32'(psel_seen), 32'(v.size <= 2));
        if (v.size <= 2) begin
            chk({tag, " setup_cycles"}, 32'(setup), 32'd1);
            chk({tag, " access_cycles"}, 32'(acc), 32'(v.e_err ? v.e_low - 1 : v.e_low));
            chk({tag, " paddr"}, 32'(cap_addr), 32'(v.addr[15:0]));
            chk({tag, " pwrite"}, 32'(cap_wr), 32'(v.wr));
            chk({tag, " pstrb"}, 32'(cap_strb), 32'(v.e_strb));
            chk({tag, " pprot"}, 32'(cap_prot), 32'({~v.prot[0], 1'b0, v.prot[1]}));
            if (v.wr) chk({tag, " pwdata"}, cap_wdata, v.wdata);
            if (!v.wr && !v.e_err) chk({tag, " hrdata"}, rd, v.rdata);
        end
        @(posedge clk); #1;
        pready = 1'b0; pslverr = 1'b0;
        @(negedge clk);
        chk({tag, " idle_psel"}, 32'(psel), 32'd0);
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        //          addr          wr  sz    prot  end  wdata          rdata          w   err  strb   low err
        tbl[0]  = '{32'h0000_0010, 1, 3'd2, 4'h3, 0, 32'h1234_5678, 32'h0,         0,  0, 4'hF,  1, 0};
        tbl[1]  = '{32'h0000_0003, 0, 3'd0, 4'h0, 0, 32'h0,         32'hA500_0000, 3,  0, 4'h0,  4, 0};
        tbl[2]  = '{32'h0000_0020, 1, 3'd2, 4'h1, 0, 32'hCAFE_F00D, 32'h0,         0,  1, 4'hF,  2, 1};
        tbl[3]  = '{32'h0000_0030, 0, 3'd2, 4'h2, 0, 32'h0,         32'h1111_2222, 10, 0, 4'h0,  5, 1};
        tbl[4]  = '{32'h0001_0041, 1, 3'd0, 4'h2, 0, 32'h0000_AB00, 32'h0,         1,  0, 4'h2,  2, 0};
        tbl[5]  = '{32'h0000_0002, 1, 3'd1, 4'h0, 1, 32'h0000_BEEF, 32'h0,         0,  0, 4'h3,  1, 0};
        tbl[6]  = '{32'h0000_0002, 1, 3'd1, 4'h3, 0, 32'hBEEF_0000, 32'h0,         2,  0, 4'hC,  3, 0};
        tbl[7]  = '{32'h0000_0001, 1, 3'd0, 4'h1, 1, 32'h00CD_0000, 32'h0,         0,  0, 4'h4,  1, 0};
        tbl[8]  = '{32'h0000_0050, 1, 3'd3, 4'h0, 0, 32'hFFFF_FFFF, 32'h0,         0,  0, 4'h0,  1, 1};
        tbl[9]  = '{32'h0000_0007, 1, 3'd2, 4'h0, 0, 32'h0BAD_0BAD, 32'h0,         3,  0, 4'hF,  4, 0};
        tbl[10] = '{32'h0000_0005, 1, 3'd1, 4'h2, 0, 32'h0000_5A5A, 32'h0,         0,  0, 4'h3,  1, 0};
        tbl[11] = '{32'h0000_8001, 1, 3'd1, 4'h1, 1, 32'h7777_0000, 32'h0,         1,  0, 4'hC,  2, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst hready", 32'(hready), 32'd1);
        chk("rst hresp", 32'(hresp), 32'd0);
        chk("rst psel", 32'(psel), 32'd0);
        chk("rst penable", 32'(penable), 32'd0);
        chk("rst paddr", 32'(paddr), 32'd0);
        chk("rst pstrb", 32'(pstrb), 32'd0);
        chk("rst pwrite", 32'(pwrite), 32'd0);
        chk("rst pprot", 32'(pprot), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // IDLE/BUSY and deselected NONSEQ must not start an APB cycle
        hsel = 1'b1; htrans = 2'b01; haddr = 32'h60; hsize = 3'd2; hwrite = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b10;
        @(negedge clk);
        chk("busy psel", 32'(psel), 32'd0);
        chk("busy hready", 32'(hready), 32'd1);
        @(posedge clk); #1;
        htrans = 2'b00;
        @(negedge clk);
        chk("nosel psel", 32'(psel), 32'd0);
        chk("nosel hresp", 32'(hresp), 32'd0);

        // back-to-back word writes to 0x0 and 0x4
        pready = 1'b1; endian = 1'b0; hprot = 4'h0;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hAAAA_0001;
        @(negedge clk);
        chk("b2b setup1 penable", 32'(penable), 32'd0);
        chk("b2b setup1 pwdata", pwdata, 32'hAAAA_0001);
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h4;
        @(negedge clk);
        chk("b2b access1 hready", 32'(hready), 32'd1);
        chk("b2b access1 penable", 32'(penable), 32'd1);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hBBBB_0002;
        @(negedge clk);
        chk("b2b setup2 psel", 32'(psel), 32'd1);
        chk("b2b setup2 penable", 32'(penable), 32'd0);
        chk("b2b setup2 paddr", 32'(paddr), 32'h4);
        chk("b2b setup2 pwdata", pwdata, 32'hBBBB_0002);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b access2 hready", 32'(hready), 32'd1);
        chk("b2b access2 pwdata", pwdata, 32'hBBBB_0002);
        @(posedge clk); #1;
        pready = 1'b0;
        @(negedge clk);
        chk("b2b idle psel", 32'(psel), 32'd0);

        // reset while stalled in ACCESS
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h1234; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstacc pre penable", 32'(penable), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstacc psel", 32'(psel), 32'd0);
        chk("rstacc penable", 32'(penable), 32'd0);
        chk("rstacc hready", 32'(hready), 32'd1);
        chk("rstacc hresp", 32'(hresp), 32'd0);
        chk("rstacc paddr", 32'(paddr), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rv.addr   = $urandom;
            rv.wr     = 1'($urandom_range(0, 1));
            rv.size   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            rv.prot   = 4'($urandom_range(0, 15));
            rv.endian = 1'($urandom_range(0, 1));
            rv.wdata  = $urandom;
            rv.rdata  = $urandom;
            rv.waits  = $urandom_range(0, 5);
            rv.slverr = ($urandom_range(0, 5) == 0);
            rv = model(rv);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
